mdio_cfg_ctrl: RTL and testbench

- MIIM (MDIO/MDC) management master and configuration sequencer for the Micrel GigE PHYs.
- Starts once the PHY strap/reset sequencer reports ready, which drives start_i.
- Writes a fixed table of PHY registers, then asserts cfg_done_o.
- After configuration, serves single read/write requests from a host port until reset.

---
 rtl/mdio_cfg_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_mdio_cfg_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_cfg_ctrl.sv
// MIIM (MDC/MDIO) master that writes a fixed PHY register table, then serves host read/write frames.
// Optional readback of every table write: define MDIO_CFG_READBACK_EN.
module mdio_cfg_ctrl #(
  parameter int                     CLK_DIV   = 25,
  parameter logic [4:0]             PHY_ADDR  = 5'd1,
  parameter int                     NUM_CFG   = 2,
  parameter logic [NUM_CFG*21-1:0]  CFG_TABLE = {5'd0, 16'h1140, 5'd4, 16'h01E1}
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i,
  output logic        cfg_done_o,
  output logic        cfg_err_o,
  output logic        busy_o,
  input  logic        host_req_i,
  input  logic        host_wr_i,
  input  logic [4:0]  host_reg_i,
  input  logic [15:0] host_wdata_i,
  output logic        host_ack_o,
  output logic [15:0] host_rdata_o
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0] IDX_LAST = 5'(NUM_CFG - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CFG, ST_FRAME, ST_CFG_NEXT, ST_READY, ST_HOST_DONE, ST_RB, ST_RB_CHK
  } state_t;

`ifdef MDIO_CFG_READBACK_EN
  localparam state_t ST_AFTER_WR = ST_RB;
`else
  localparam state_t ST_AFTER_WR = ST_CFG_NEXT;
`endif

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               mdc_q, mdc_d;
  logic               mdio_q, mdio_d;
  logic               oe_q, oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ack_q, ack_d;
  logic [15:0]        rdata_q, rdata_d;
  logic [4:0]         idx_q, idx_d;
  logic [5:0]         bit_q, bit_d;
  logic [63:0]        frame_q, frame_d;
  logic [15:0]        sh_q, sh_d;
  logic               rd_q, rd_d;
  logic               host_q, host_d;
  logic               rb_q, rb_d;
`ifdef MDIO_CFG_READBACK_EN
  logic               err_q, err_d;
`endif

  logic [20:0]        entry;
  logic               launch, launch_rd;
  logic [4:0]         launch_reg;
  logic [15:0]        launch_data;

  // Whole frame as shifted out MSB first; read frames carry zeros where the bus is released.
  function automatic logic [63:0] build_frame(input logic rd, input logic [4:0] regad,
                                              input logic [15:0] data);
    build_frame = {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), PHY_ADDR, regad,
                   (rd ? 2'b00 : 2'b10), (rd ? 16'h0000 : data)};
  endfunction

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    mdc_d       = mdc_q;
    mdio_d      = mdio_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    done_d      = done_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    idx_d       = idx_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    sh_d        = sh_q;
    rd_d        = rd_q;
    host_d      = host_q;
    rb_d        = rb_q;
`ifdef MDIO_CFG_READBACK_EN
    err_d       = err_q;
`endif
    entry       = CFG_TABLE[21*(NUM_CFG-1-int'(idx_q)) +: 21];
    launch      = 1'b0;
    launch_rd   = 1'b0;
    launch_reg  = 5'd0;
    launch_data = 16'h0000;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          idx_d   = 5'd0;
          state_d = ST_CFG;
        end
      end
      ST_CFG: begin
        launch      = 1'b1;
        launch_reg  = entry[20:16];
        launch_data = entry[15:0];
        host_d      = 1'b0;
        rb_d        = 1'b0;
        state_d     = ST_FRAME;
      end
      ST_FRAME: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          mdc_d = ~mdc_q;
          if (!mdc_q) begin
            sh_d = {sh_q[14:0], mdio_i};
          end else if (bit_q == 6'd63) begin
            // 64th falling edge: release the bus and hand off in the same cycle
            busy_d = 1'b0;
            oe_d   = 1'b0;
            mdio_d = 1'b0;
            if (host_q) begin
              ack_d   = 1'b1;
              state_d = ST_HOST_DONE;
              if (rd_q) rdata_d = sh_q;
            end else if (rb_q) begin
              state_d = ST_RB_CHK;
            end else begin
              state_d = ST_AFTER_WR;
            end
          end else begin
            bit_d   = bit_q + 6'd1;
            frame_d = {frame_q[62:0], 1'b0};
            mdio_d  = frame_q[62];
            oe_d    = !(rd_q && (bit_q >= 6'd45));
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_CFG_NEXT: begin
        if (idx_q == IDX_LAST) begin
          done_d  = 1'b1;
          state_d = ST_READY;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = ST_CFG;
        end
      end
      ST_READY: begin
        if (host_req_i) begin
          launch      = 1'b1;
          launch_rd   = !host_wr_i;
          launch_reg  = host_reg_i;
          launch_data = host_wdata_i;
          host_d      = 1'b1;
          rb_d        = 1'b0;
          state_d     = ST_FRAME;
        end
      end
      ST_HOST_DONE: begin
        state_d = ST_READY;
      end
`ifdef MDIO_CFG_READBACK_EN
      ST_RB: begin
        launch     = 1'b1;
        launch_rd  = 1'b1;
        launch_reg = entry[20:16];
        rb_d       = 1'b1;
        state_d    = ST_FRAME;
      end
      ST_RB_CHK: begin
        if (sh_q != entry[15:0]) err_d = 1'b1;
        state_d = ST_CFG_NEXT;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // First preamble bit is presented immediately, with MDC still low.
    if (launch) begin
      frame_d = build_frame(launch_rd, launch_reg, launch_data);
      mdio_d  = 1'b1;
      oe_d    = 1'b1;
      busy_d  = 1'b1;
      div_d   = '0;
      mdc_d   = 1'b0;
      bit_d   = 6'd0;
      rd_d    = launch_rd;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      mdc_q   <= 1'b0;
      mdio_q  <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 16'h0000;
      idx_q   <= 5'd0;
      bit_q   <= 6'd0;
      frame_q <= 64'h0;
      sh_q    <= 16'h0000;
      rd_q    <= 1'b0;
      host_q  <= 1'b0;
      rb_q    <= 1'b0;
`ifdef MDIO_CFG_READBACK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      mdc_q   <= mdc_d;
      mdio_q  <= mdio_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      sh_q    <= sh_d;
      rd_q    <= rd_d;
      host_q  <= host_d;
      rb_q    <= rb_d;
`ifdef MDIO_CFG_READBACK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign mdc_o        = mdc_q;
  assign mdio_o       = mdio_q;
  assign mdio_oe_o    = oe_q;
  assign busy_o       = busy_q;
  assign cfg_done_o   = done_q;
  assign host_ack_o   = ack_q;
  assign host_rdata_o = rdata_q;
`ifdef MDIO_CFG_READBACK_EN
  assign cfg_err_o    = err_q;
`else
  assign cfg_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_cfg_ctrl.sv
// Bench for mdio_cfg_ctrl: PHY register-file model on the MDIO pins plus a frame-level scoreboard.
module tb_mdio_cfg_ctrl;

`ifdef MDIO_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int NCF = RB ? 4 : 2;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        mdc_o, mdio_o, mdio_oe_o;
  logic        mdio_i = 1'b0;
  logic        cfg_done_o, cfg_err_o, busy_o;
  logic        host_req_i = 1'b0, host_wr_i = 1'b0;
  logic [4:0]  host_reg_i = 5'd0;
  logic [15:0] host_wdata_i = 16'h0;
  logic        host_ack_o;
  logic [15:0] host_rdata_o;

  mdio_cfg_ctrl #(
    .CLK_DIV(2), .PHY_ADDR(5'd1), .NUM_CFG(2),
    .CFG_TABLE({5'd0, 16'h1140, 5'd4, 16'h01E1})
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i),
    .mdc_o(mdc_o), .mdio_o(mdio_o), .mdio_oe_o(mdio_oe_o), .mdio_i(mdio_i),
    .cfg_done_o(cfg_done_o), .cfg_err_o(cfg_err_o), .busy_o(busy_o),
    .host_req_i(host_req_i), .host_wr_i(host_wr_i), .host_reg_i(host_reg_i),
    .host_wdata_i(host_wdata_i), .host_ack_o(host_ack_o), .host_rdata_o(host_rdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] bits;
    logic [63:0] oem;
    int          n;
    int          blen;
    logic        end_pins;
  } frm_t;

  frm_t        obs_q[$];
  logic [15:0] phy_regs [32];
  logic [15:0] ref_regs [32];
  logic [15:0] last_rd = 16'h0;
  int          n_cmp = 0, n_bad = 0, ack_cnt = 0;

  logic [63:0] m_bits = 64'h0, m_oem = 64'h0;
  int          m_n = 0, m_blen = 0;
  logic        m_in = 1'b0, m_mdc_p = 1'b0, m_busy_p = 1'b0, m_rd = 1'b0;
  logic [15:0] m_rv = 16'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] phy_read(input logic [4:0] ra);
    if (RB && ra == 5'd0) return 16'h1141;
    return phy_regs[ra];
  endfunction

  // PHY model: samples on MDC rise, drives read data after the rise, applies writes at frame end.
  always @(negedge clk) begin
    if (!reset_n_i) begin
      m_in = 1'b0; m_mdc_p = 1'b0; m_busy_p = 1'b0; mdio_i = 1'b0;
    end else begin
      if (busy_o && !m_busy_p) begin
        m_in = 1'b1; m_n = 0; m_bits = 64'h0; m_oem = 64'h0; m_blen = 0; m_rd = 1'b0; mdio_i = 1'b0;
      end
      if (m_in && busy_o) m_blen++;
      if (m_in && mdc_o && !m_mdc_p && m_n < 64) begin
        m_bits[63-m_n] = mdio_oe_o & mdio_o;
        m_oem[63-m_n]  = mdio_oe_o;
        m_n++;
        if (m_n == 46) begin
          m_rd = (m_bits[29:28] == 2'b10);
          m_rv = phy_read(m_bits[22:18]);
        end
        mdio_i = 1'b0;
        if (m_rd && m_n >= 48 && m_n <= 63) mdio_i = m_rv[63-m_n];
      end
      if (m_in && !busy_o && m_busy_p) begin
        obs_q.push_back('{bits: m_bits, oem: m_oem, n: m_n, blen: m_blen, end_pins: mdio_oe_o | mdc_o});
        if (m_n == 64 && m_bits[29:28] == 2'b01) phy_regs[m_bits[22:18]] = m_bits[15:0];
        m_in = 1'b0;
        mdio_i = 1'b0;
      end
      m_mdc_p  = mdc_o;
      m_busy_p = busy_o;
      if (host_ack_o) ack_cnt++;
    end
  end

  task automatic check_frame(input string tag, input bit rd, input logic [4:0] ra, input logic [15:0] d);
    frm_t f;
    logic [63:0] eb, eo;
    chk({tag, "_present"}, 64'(obs_q.size() > 0), 64'd1);
    if (obs_q.size() > 0) begin
      f  = obs_q.pop_front();
      eb = {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), 5'd1, ra, (rd ? 2'b00 : 2'b10), (rd ? 16'h0 : d)};
      eo = rd ? (~64'h0 << 18) : ~64'h0;
      chk({tag, "_bits"}, f.bits, eb);
      chk({tag, "_oe"}, f.oem, eo);
      chk({tag, "_mdc_cycles"}, 64'(f.n), 64'd64);
      chk({tag, "_busy_len"}, 64'(f.blen), 64'd256);
      chk({tag, "_end_idle"}, 64'(f.end_pins), 64'd0);
    end
  endtask

  task automatic wait_ack(input string tag);
    int cyc = 0;
    while (!host_ack_o && cyc < 1000) begin @(negedge clk); cyc++; end
    chk(tag, 64'(host_ack_o), 64'd1);
  endtask

  task automatic host_op(input bit wr, input logic [4:0] ra, input logic [15:0] d);
    int a0 = ack_cnt;
    host_wr_i = wr; host_reg_i = ra; host_wdata_i = d; host_req_i = 1'b1;
    wait_ack("host_ack_seen");
    host_req_i = 1'b0;
    if (!wr) begin
      chk("host_rdata", host_rdata_o, ref_regs[ra]);
      last_rd = ref_regs[ra];
    end else begin
      ref_regs[ra] = d;
      chk("host_rdata_hold", host_rdata_o, last_rd);
    end
    @(negedge clk);
    chk("host_ack_pulse", 64'(host_ack_o), 64'd0);
    chk("host_ack_cnt", 64'(ack_cnt - a0), 64'd1);
    check_frame(wr ? "host_wr" : "host_rd", !wr, ra, d);
  endtask

  initial begin
    logic [4:0]  ra0, ra;
    logic [15:0] d0, d;
    logic [4:0]  cfg_reg [2];
    logic [15:0] cfg_dat [2];
    int          cyc, a0;
    bit          wr;
    cfg_reg[0] = 5'd0; cfg_dat[0] = 16'h1140;
    cfg_reg[1] = 5'd4; cfg_dat[1] = 16'h01E1;
    for (int i = 0; i < 32; i++) begin
      phy_regs[i] = 16'($urandom);
      ref_regs[i] = phy_regs[i];
    end
    phy_regs[1] = 16'h796D;
    ref_regs[1] = 16'h796D;

    repeat (3) @(negedge clk);
    chk("reset_outs", {mdc_o, mdio_o, mdio_oe_o, cfg_done_o, cfg_err_o, busy_o, host_ack_o, host_rdata_o}, 64'd0);
    reset_n_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_no_start", 64'(busy_o), 64'd0);

    // Abort frame 0 at MDC cycle 40 with an asynchronous reset.
    start_i = 1'b1;
    cyc = 0;
    while (m_n < 40 && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("abort_reached", 64'(m_n >= 40), 64'd1);
    chk("abort_pre_busy", 64'(busy_o), 64'd1);
    reset_n_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk("abort_pins", {mdc_o, mdio_oe_o, busy_o, host_ack_o}, 64'd0);
    @(negedge clk);
    chk("abort_no_frame", 64'(obs_q.size()), 64'd0);
    reset_n_i = 1'b1;

    // Host request held during configuration must wait for cfg_done_o.
    ra0 = 5'($urandom_range(2, 31));
    d0  = 16'($urandom);
    host_wr_i = 1'b1; host_reg_i = ra0; host_wdata_i = d0; host_req_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("req_no_start", 64'(busy_o), 64'd0);
    start_i = 1'b1;
    repeat (5) @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (!cfg_done_o && cyc < 5000) begin @(negedge clk); cyc++; end
    chk("cfg_done", 64'(cfg_done_o), 64'd1);
    chk("cfg_no_ack", 64'(ack_cnt), 64'd0);
    chk("cfg_err", 64'(cfg_err_o), 64'(RB));
    chk("host_wait", 64'(busy_o), 64'd0);
    chk("cfg_frames", 64'(obs_q.size()), 64'(NCF));
    for (int i = 0; i < 2; i++) begin
      check_frame("cfg_wr", 1'b0, cfg_reg[i], cfg_dat[i]);
      if (RB) check_frame("cfg_rb", 1'b1, cfg_reg[i], 16'h0);
      ref_regs[cfg_reg[i]] = cfg_dat[i];
    end
    @(negedge clk);
    chk("host_start", 64'(busy_o), 64'd1);
    host_op(1'b1, ra0, d0);
    host_op(1'b0, 5'd1, 16'h0);

    // Back-to-back writes with the request held across two acks.
    a0 = ack_cnt;
    ra = 5'($urandom_range(1, 31));
    d  = 16'($urandom);
    host_wr_i = 1'b1; host_reg_i = ra; host_wdata_i = d; host_req_i = 1'b1;
    wait_ack("b2b_ack1");
    @(negedge clk);
    wait_ack("b2b_ack2");
    host_req_i = 1'b0;
    ref_regs[ra] = d;
    @(negedge clk);
    chk("b2b_ack_cnt", 64'(ack_cnt - a0), 64'd2);
    check_frame("b2b_1", 1'b0, ra, d);
    check_frame("b2b_2", 1'b0, ra, d);
    repeat (300) @(negedge clk);
    chk("b2b_no_extra_ack", 64'(ack_cnt - a0), 64'd2);
    chk("b2b_no_extra_frame", 64'(obs_q.size()), 64'd0);

    // Randomized host traffic checked against the reference register file.
    for (int k = 0; k < 8; k++) begin
      wr = 1'($urandom_range(0, 1));
      ra = 5'($urandom_range(1, 31));
      d  = 16'($urandom);
      host_op(wr, ra, d);
    end
    chk("cfg_done_held", 64'(cfg_done_o), 64'd1);
    chk("cfg_err_final", 64'(cfg_err_o), 64'(RB));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
